// File: rtl/inspeccion_pkg.sv
// Shared types for the inspection station: verdict codes from the inspection FSM
// and the sorter actuation states.
package inspeccion_pkg;

  typedef enum logic [1:0] {
    NADA      = 2'b00,
    AVANZAR   = 2'b01,
    RECHAZADO = 2'b10,
    APROBADO  = 2'b11
  } verdict_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EJECT = 2'b01,
    PASS  = 2'b10,
    GUARD = 2'b11
  } sorter_state_t;

  // Bits needed to hold max(p, g) - 1, never less than one.
  function automatic int timer_width(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/inspeccion_sorter_sat_counter.sv
// Saturating up-counter: counts inc pulses and holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/inspeccion_sorter.sv
// Sorter actuator: turns inspection verdicts into timed gate pulses with a guard gap,
// buffers one verdict during an actuation and keeps saturating tallies.
module inspeccion_sorter
  import inspeccion_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       E,
  output logic             motor_on,
  output logic             reject_gate,
  output logic             accept_gate,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] approved_cnt,
  output logic [CNT_W-1:0] rejected_cnt
);

  localparam int TW = timer_width(PULSE_CYCLES, GUARD_CYCLES);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);

  sorter_state_t state;
  logic [TW-1:0] timer;
  logic          pend_valid;
  logic          pend_rej;

  // E is a per-cycle strobe with no ready: a 10/11 code is one event consumed on
  // the edge it is sampled. While an actuation runs the single pending slot absorbs
  // one event; anything beyond that is dropped and recorded in overrun.
  logic ev, ev_rej;
  logic disp_pend, disp_live, disp, disp_rej;
  logic store, drop;

  assign ev        = (E == RECHAZADO) || (E == APROBADO);
  assign ev_rej    = (E == RECHAZADO);
  assign disp_pend = pend_valid &&
                     ((state == IDLE) || ((state == GUARD) && (timer == '0)));
  assign disp_live = ev && (state == IDLE) && !pend_valid;
  assign disp      = disp_pend || disp_live;
  assign disp_rej  = disp_pend ? pend_rej : ev_rej;
  assign store     = ev && !disp_live && (!pend_valid || disp_pend);
  assign drop      = ev && !disp_live && pend_valid && !disp_pend;

  assign busy = (state != IDLE) || pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      reject_gate <= 1'b0;
      accept_gate <= 1'b0;
    end else if (disp) begin
      state       <= disp_rej ? EJECT : PASS;
      timer       <= PULSE_LOAD;
      reject_gate <= disp_rej;
      accept_gate <= !disp_rej;
    end else begin
      case (state)
        IDLE: begin
          reject_gate <= 1'b0;
          accept_gate <= 1'b0;
        end
        EJECT, PASS: begin
          if (timer == '0) begin
            state       <= GUARD;
            timer       <= GUARD_LOAD;
            reject_gate <= 1'b0;
            accept_gate <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GUARD: begin
          if (timer == '0) begin
            state <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          timer       <= '0;
          reject_gate <= 1'b0;
          accept_gate <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_rej   <= 1'b0;
      overrun    <= 1'b0;
      motor_on   <= 1'b0;
    end else begin
      motor_on <= (E == AVANZAR);
      if (store) begin
        pend_valid <= 1'b1;
        pend_rej   <= ev_rej;
      end else if (disp_pend) begin
        pend_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

  // Tallies advance on dispatch, so dropped verdicts are never counted.
  sat_counter #(.W(CNT_W)) u_approved (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (disp && !disp_rej),
    .count (approved_cnt)
  );

  sat_counter #(.W(CNT_W)) u_rejected (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (disp && disp_rej),
    .count (rejected_cnt)
  );

endmodule

// File: doc/inspeccion_sorter.md
Name: inspeccion_sorter

Overview:
- Downstream actuator controller for the inspection station.
- Consumes the 2-bit inspection verdict code E from the inspection FSM and drives the conveyor motor, reject gate and accept gate.
- Keeps saturating tallies of approved and rejected products, buffers one verdict while an actuation is in progress, and flags lost verdicts.
- Sits between the inspection FSM and the top-level I/O pins.

Parameters:
PULSE_CYCLES, 4, cycles a gate stays energised per actuation (>=1)
GUARD_CYCLES, 2, cycles both gates stay off after a pulse before the next actuation (>=1)
CNT_W, 8, width of each tally counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  reset, asynchronous and active-low
E  input  2  verdict code: 00 none, 01 advance, 10 rejected, 11 approved
motor_on  output  1  conveyor motor enable
reject_gate  output  1  reject diverter solenoid
accept_gate  output  1  accept diverter solenoid
busy  output  1  actuation in progress or verdict pending
overrun  output  1  sticky: a verdict was dropped
approved_cnt  output  CNT_W  approved tally, saturating
rejected_cnt  output  CNT_W  rejected tally, saturating

Behaviour:
- Reset (rst_n=0, any time, including mid-pulse):
  - state=IDLE; pending empty.
  - All outputs 0, counters 0, gates released immediately.
- motor_on is registered: motor_on <= (E==01). One-cycle latency, independent of the gate FSM.
- Event decode, per cycle: E==10 gives a reject event, E==11 gives an approve event, 00 and 01 give no event. Each cycle that E carries 10 or 11 counts as one event.
- States are IDLE, EJECT, PASS and GUARD. There is one down-timer, wide enough for max(PULSE_CYCLES, GUARD_CYCLES).
- IDLE:
  - Pending has priority over a live event.
  - Reject goes to EJECT, approve goes to PASS, loading timer = PULSE_CYCLES-1.
  - The matching counter increments on the same edge (dispatch time).
- EJECT / PASS:
  - reject_gate=1 (EJECT) or accept_gate=1 (PASS).
  - Timer decrements. When timer==0, go to GUARD with timer = GUARD_CYCLES-1.
- GUARD:
  - Both gates 0.
  - When timer==0: if pending is valid, dispatch it directly into EJECT/PASS (reload timer, increment counter, clear pending); otherwise go to IDLE.
- Gate outputs are decoded from the registered state. A verdict sampled at edge n gives a gate high from cycle n+1 for exactly PULSE_CYCLES cycles.
- reject_gate and accept_gate are never both 1.
- Pending is a one-deep buffer of the verdict type.
  - An event arriving while state!=IDLE is stored if pending is empty.
  - If pending is full, the event is dropped: overrun <= 1 (sticky until reset), and it is not counted.
  - If pending is dispatched on the same edge a new event arrives, the new event is stored (free-and-reload, no overrun).
- busy = (state!=IDLE) | pending_valid.
- Counters saturate at 2^CNT_W-1; further dispatches leave them unchanged.
- Unreachable state encodings return to IDLE with gates off.

Decomposition:
- Shared package inspeccion_pkg:
  - verdict-code enum (NADA=00, AVANZAR=01, RECHAZADO=10, APROBADO=11), also used by the inspection FSM;
  - sorter state enum.
- One sub-module: sat_counter (parameter W; inputs clk, rst_n, inc; output count). Instantiated twice.

Test Plan:
1. Single reject, defaults: E=10 at cycle 0 only -> reject_gate=1 cycles 1-4, 0 at cycles 5-6, busy=1 cycles 1-6, rejected_cnt=1 from cycle 1, approved_cnt=0, overrun=0.
2. Back-to-back verdicts: E=11 at cycle 0, E=10 at cycle 3 -> accept_gate 1-4, guard 5-6, reject_gate 7-10, busy=1 through cycle 12, approved_cnt=1 from cycle 1, rejected_cnt=1 from cycle 7.
3. Overrun: E=10 at cycle 0, E=11 at 2, E=10 at 3 -> third event dropped, overrun=1 from cycle 4 and stays 1, final counts rejected=1 approved=1.
4. Saturation, CNT_W=2: six isolated rejects spaced 10 cycles apart -> rejected_cnt 1,2,3,3,3,3 and never wraps to 0.
5. Reset mid-pulse: E=11 at cycle 0, rst_n=0 asynchronously at cycle 2.5 -> accept_gate, busy and counters drop to 0 immediately; after release, no residual pulse and pending is empty.
6. Motor follow: E=01 for cycles 0-5, then 00 -> motor_on=1 cycles 1-6, 0 from cycle 7; no gate activity, busy=0.
